uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//
// Consumes the SoC UART transmit line and presents received bytes on a
// valid/ready stream, with sticky framing and overflow error flags.
//
// Ports:
//   clock      system clock
//   RSTB       asynchronous active-low reset
//   ser_rx     serial input, idles high, asynchronous to clock
//   m_data     head-of-FIFO byte
//   m_valid    FIFO not empty
//   m_ready    consumer accepts the head byte when m_valid & m_ready
//   count      FIFO occupancy, 0..DEPTH
//   frame_err  sticky: stop bit sampled low
//   overflow   sticky: a good byte was dropped because the FIFO was full
//   err_clr    synchronous clear of both sticky flags (a same-cycle set wins)
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8,
    parameter int CW           = 4
) (
    input  logic          clock,
    input  logic          RSTB,
    input  logic          ser_rx,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [CW-1:0] count,
    output logic          frame_err,
    output logic          overflow,
    input  logic          err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    logic          rx_meta_q, rx_s_q;
    state_e        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push_req, frame_set;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          frame_err_q, overflow_q;
    logic          pop, full, push_ok, ovf_set;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= ser_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        bidx_d    = bidx_q;
        shreg_d   = shreg_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    bcnt_d  = '0;
                end
            end
            S_START: begin
                // Re-check the line half a bit in to reject short glitches.
                if (bcnt_q == HALF_BIT) begin
                    bcnt_d = '0;
                    bidx_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bcnt_q == LAST_BIT) begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    bcnt_d  = '0;
                    bidx_d  = bidx_q + 1'b1;
                    if (bidx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Returning to IDLE mid stop bit lets the next start edge
                // be caught with zero idle time between frames.
                if (bcnt_q == LAST_BIT) begin
                    bcnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_WAIT_IDLE;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A push into a full FIFO succeeds only when the head is popped in the
    // same cycle; wptr then equals rptr and the popped slot is reused.
    always_comb begin
        pop     = m_valid & m_ready;
        full    = (count_q == CW'(DEPTH));
        push_ok = push_req & (~full | pop);
        ovf_set = push_req & full & ~pop;
        count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop};
    end

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= shreg_q;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= frame_set | (frame_err_q & ~err_clr);
            overflow_q  <= ovf_set   | (overflow_q  & ~err_clr);
        end
    end

    assign m_data    = mem_q[rptr_q];
    assign m_valid   = (count_q != '0);
    assign count     = count_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo.
// Drives 8N1 frames on ser_rx, collects accepted beats from the stream
// interface and compares them with a queue-based model of the FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clock   = 1'b0;
    logic          RSTB    = 1'b0;
    logic          ser_rx  = 1'b1;
    logic          m_ready = 1'b1;
    logic          err_clr = 1'b0;
    logic [7:0]    m_data;
    logic          m_valid;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit         rand_ready = 1'b0;
    bit         exp_ovf;
    logic [7:0] hold_data;
    bit         hold = 1'b0;

    always #5 clock = ~clock;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DEPTH       (DEPTH),
        .CW          (CW)
    ) dut (
        .clock    (clock),
        .RSTB     (RSTB),
        .ser_rx   (ser_rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .count    (count),
        .frame_err(frame_err),
        .overflow (overflow),
        .err_clr  (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bit_time(input logic v);
        ser_rx = v;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] b);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(1'b1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_beats"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    endtask

    // Stream monitor: records every accepted beat and checks that the head
    // byte holds while the consumer stalls.
    always @(negedge clock) begin
        if (!RSTB) begin
            hold = 1'b0;
        end else begin
            if (hold) check("m_data_stable", m_data, hold_data);
            if (m_valid && m_ready) got.push_back(m_data);
            hold      = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    always @(posedge clock) begin
        if (rand_ready) begin
            #1;
            m_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] b;

        // Reset state
        repeat (3) tick();
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_count", count, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        RSTB = 1'b1;
        repeat (5) tick();

        // Single byte with latency from the start edge
        got.delete();
        lat = -1;
        fork
            send_frame(8'hA5);
            begin
                for (int n = 1; n <= 300 && lat < 0; n++) begin
                    tick();
                    if (m_valid) lat = n;
                end
            end
        join
        repeat (20) tick();
        check("a5_latency_in_window", (lat >= 154 && lat <= 156), 1);
        exp_q = '{8'hA5};
        check_stream("a5");
        check("a5_frame_err", frame_err, 0);
        check("a5_overflow", overflow, 0);

        // Back-to-back "AB01" with no idle bits
        got.delete();
        exp_q = '{8'h41, 8'h42, 8'h30, 8'h31};
        foreach (exp_q[i]) send_frame(exp_q[i]);
        repeat (40) tick();
        check_stream("ab01");
        check("ab01_frame_err", frame_err, 0);
        check("ab01_overflow", overflow, 0);

        // Short low glitch is rejected silently
        got.delete();
        ser_rx = 1'b0;
        repeat (4) tick();
        ser_rx = 1'b1;
        repeat (40) tick();
        check("glitch_beats", got.size(), 0);
        check("glitch_m_valid", m_valid, 0);
        check("glitch_frame_err", frame_err, 0);

        // Stop bit held low for 20 bit times, then a clean frame
        got.delete();
        b = 8'h3C;
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        ser_rx = 1'b0;
        repeat (20 * CPB) tick();
        check("brk_frame_err", frame_err, 1);
        check("brk_m_valid", m_valid, 0);
        ser_rx = 1'b1;
        repeat (CPB) tick();
        send_frame(8'h7E);
        repeat (20) tick();
        exp_q = '{8'h7E};
        check_stream("after_brk");
        check("brk_sticky", frame_err, 1);
        pulse_clr();
        check("brk_cleared", frame_err, 0);

        // Overflow: consumer stalled, ten bytes offered to an 8-deep FIFO
        got.delete();
        exp_q.delete();
        exp_ovf = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_frame(8'(i));
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
            else exp_ovf = 1'b1;
        end
        repeat (20) tick();
        check("ovf_count", count, exp_q.size());
        check("ovf_flag", overflow, exp_ovf);
        check("ovf_head", m_data, exp_q[0]);
        m_ready = 1'b1;
        repeat (30) tick();
        check_stream("ovf_drain");
        check("ovf_drained_count", count, 0);
        pulse_clr();
        check("ovf_cleared", overflow, 0);

        // Full FIFO with a single pop landing on the stop-sample cycle
        got.delete();
        exp_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55);
            begin
                repeat (154) tick();
                m_ready = 1'b1;
                tick();
                m_ready = 1'b0;
            end
        join
        repeat (10) tick();
        check("fullpop_overflow", overflow, 0);
        check("fullpop_count", count, DEPTH);
        m_ready = 1'b1;
        repeat (30) tick();
        check_stream("fullpop");

        // Asynchronous reset during data bit 3
        got.delete();
        m_ready = 1'b0;
        send_frame(8'h5A);
        repeat (4) tick();
        check("prerst_m_valid", m_valid, 1);
        check("prerst_m_data", m_data, 8'h5A);
        fork
            send_frame(8'hFA);
            begin
                repeat (CPB * 4 + 6) tick();
                #2;
                RSTB = 1'b0;
                #1;
                check("midrst_m_valid", m_valid, 0);
                check("midrst_m_data", m_data, 0);
                check("midrst_count", count, 0);
                check("midrst_frame_err", frame_err, 0);
                check("midrst_overflow", overflow, 0);
                tick();
                RSTB = 1'b1;
            end
        join
        m_ready = 1'b1;
        repeat (CPB) tick();
        pulse_clr();
        got.delete();
        send_frame(8'hC3);
        repeat (20) tick();
        exp_q = '{8'hC3};
        check_stream("postrst");
        check("postrst_frame_err", frame_err, 0);

        // Randomized bytes, gaps and consumer backpressure
        got.delete();
        exp_q.delete();
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            send_frame(b);
            exp_q.push_back(b);
            repeat ($urandom_range(0, 2)) bit_time(1'b1);
        end
        rand_ready = 1'b0;
        #2;
        m_ready = 1'b1;
        repeat (40) tick();
        check_stream("rand");
        check("rand_overflow", overflow, 0);
        check("rand_frame_err", frame_err, 0);
        check("rand_empty", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
